bin_to_bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm. It generalises the 4-bit 0–9 binary-to-BCD mapping to any input width and digit count. It uses a start/done handshake and has fixed, width-determined latency. It sits between datapath counters/accumulators and display/decoder logic (e.g. 7-segment drivers) that need decimal digits.

---
 rtl/bin_to_bcd_seq.sv | 98 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3).
// One iteration per clock, start/done handshake, overflow flag.
module bin_to_bcd_seq #(
  parameter int BIN_W      = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    ovf
);

  localparam int ACC_W = 4 * BCD_DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           r_state;
  logic [BIN_W-1:0] r_bin;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_acc;
  logic             r_busy;
  logic             r_done;
  logic [ACC_W-1:0] r_bcd;
  logic             r_ovf;

  logic [ACC_W-1:0] w_adj;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_carry;

  always_comb begin
    w_adj = '0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      else
        w_adj[4*d +: 4] = r_acc[4*d +: 4];
    end
  end

  // A set MSB after adjust is a carry into the missing next digit.
  assign w_carry   = w_adj[ACC_W-1];
  assign w_acc_nxt = {w_adj[ACC_W-2:0], r_bin[BIN_W-1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_bin     <= bin_in;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= CONV;
          end
        end
        CONV: begin
          r_bin     <= r_bin << 1;
          r_acc     <= w_acc_nxt;
          r_ovf_acc <= r_ovf_acc | w_carry;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_bcd   <= w_acc_nxt;
            r_ovf   <= r_ovf_acc | w_carry;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bcd_out = r_bcd;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations,
// table vectors, sweeps, and scoreboarded results.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  st;
  logic [7:0]  bin_a;
  logic [7:0]  bin_b;
  logic [15:0] bin_c;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  ovf;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
  } exp_t;

  typedef struct {
    int          id;
    int unsigned val;
    logic [19:0] bcd;
    logic        ovf;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  bin_to_bcd_seq #(.BIN_W(8), .BCD_DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .bin_in(bin_a),
    .busy(busy[0]), .done(done[0]), .bcd_out(bcd_a), .ovf(ovf[0]));

  bin_to_bcd_seq #(.BIN_W(8), .BCD_DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .bin_in(bin_b),
    .busy(busy[1]), .done(done[1]), .bcd_out(bcd_b), .ovf(ovf[1]));

  bin_to_bcd_seq #(.BIN_W(16), .BCD_DIGITS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .bin_in(bin_c),
    .busy(busy[2]), .done(done[2]), .bcd_out(bcd_c), .ovf(ovf[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  function automatic exp_t model(int unsigned v, int d);
    exp_t r;
    int unsigned m = 1;
    int unsigned x;
    for (int i = 0; i < d; i++) m = m * 10;
    r.ovf = (v >= m);
    x = v % m;
    r.bcd = '0;
    for (int i = 0; i < d; i++) begin
      r.bcd[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [19:0] get_bcd(int id);
    case (id)
      0: return {8'h0, bcd_a};
      1: return {12'h0, bcd_b};
      default: return bcd_c;
    endcase
  endfunction

  function automatic int digits(int id);
    return (id == 0) ? 3 : (id == 1) ? 2 : 5;
  endfunction

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) begin
        exp_t e;
        int   sz;
        sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
          total++;
          $display("FAIL extra_done dut%0d: got done=1 expected none", i);
        end else begin
          case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("bcd dut%0d", i), 32'(get_bcd(i)), 32'(e.bcd));
          chk($sformatf("ovf dut%0d", i), 32'(ovf[i]), 32'(e.ovf));
        end
      end
    end
  end

  task automatic push(int id, exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic set_bin(int id, int unsigned v);
    case (id)
      0: bin_a = 8'(v);
      1: bin_b = 8'(v);
      default: bin_c = 16'(v);
    endcase
  endtask

  // Called at a negedge while idle; returns at the negedge showing done.
  task automatic conv(int id, int unsigned v, exp_t e, bit full);
    int acc, nb, g, lat;
    bit stable;
    logic [19:0] prev;
    prev = get_bcd(id);
    st[id] = 1'b1;
    set_bin(id, v);
    push(id, e);
    @(negedge clk);
    acc = cyc;
    st[id] = 1'b0;
    set_bin(id, $urandom);
    nb = 0;
    g = 0;
    stable = 1'b1;
    while (!done[id] && g < 40) begin
      if (busy[id]) nb++;
      if (get_bcd(id) !== prev) stable = 1'b0;
      @(negedge clk);
      g++;
    end
    lat = (id == 2) ? 16 : 8;
    if (!done[id]) begin
      chk($sformatf("done_timeout dut%0d", id), 32'(done[id]), 32'd1);
    end else if (full) begin
      chk($sformatf("latency dut%0d", id), 32'(cyc - acc), 32'(lat));
      chk($sformatf("busy_cycles dut%0d", id), 32'(nb), 32'(lat));
      chk($sformatf("hold_busy dut%0d", id), 32'(stable), 32'd1);
    end
  endtask

  vec_t tbl[$];

  initial begin
    exp_t e;
    int g;
    tbl = '{
      '{0, 255,   20'h00255, 1'b0},
      '{0, 0,     20'h00000, 1'b0},
      '{0, 9,     20'h00009, 1'b0},
      '{0, 10,    20'h00010, 1'b0},
      '{0, 99,    20'h00099, 1'b0},
      '{0, 100,   20'h00100, 1'b0},
      '{1, 255,   20'h00055, 1'b1},
      '{1, 99,    20'h00099, 1'b0},
      '{1, 100,   20'h00000, 1'b1},
      '{1, 0,     20'h00000, 1'b0},
      '{2, 65535, 20'h65535, 1'b0},
      '{2, 10000, 20'h10000, 1'b0},
      '{2, 9999,  20'h09999, 1'b0}
    };
    st = '0;
    bin_a = '0;
    bin_b = '0;
    bin_c = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_busy dut%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_done dut%0d", i), 32'(done[i]), 32'd0);
      chk($sformatf("rst_bcd dut%0d", i), 32'(get_bcd(i)), 32'd0);
      chk($sformatf("rst_ovf dut%0d", i), 32'(ovf[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      e.bcd = tbl[i].bcd;
      e.ovf = tbl[i].ovf;
      conv(tbl[i].id, tbl[i].val, e, 1'b1);
      @(negedge clk);
    end

    // Back-to-back sweeps: next start is issued in the done cycle
    for (int v = 0; v < 256; v++) conv(0, v, model(v, 3), 1'b1);
    @(negedge clk);
    for (int v = 0; v < 256; v++) conv(1, v, model(v, 2), 1'b0);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      int unsigned v;
      v = $urandom_range(65535);
      conv(2, v, model(v, 5), 1'b0);
    end
    @(negedge clk);

    // Starts while busy are ignored
    st[0] = 1'b1;
    bin_a = 8'd37;
    push(0, model(37, 3));
    @(negedge clk);
    st[0] = 1'b0;
    bin_a = 8'd200;
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    g = 0;
    while (!done[0] && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("ignored_start_done", 32'(done[0]), 32'd1);
    repeat (12) @(negedge clk);
    chk("ignored_start_busy", 32'(busy[0]), 32'd0);

    // Reset mid-conversion discards the result
    st[0] = 1'b1;
    bin_a = 8'd128;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_done", 32'(done[0]), 32'd0);
    chk("midrst_bcd", 32'(bcd_a), 32'd0);
    chk("midrst_ovf", 32'(ovf[0]), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done_q", 32'(q0.size()), 32'd0);
    conv(0, 64, model(64, 3), 1'b1);

    // Held result between conversions
    @(negedge clk);
    conv(2, 65535, model(65535, 5), 1'b1);
    repeat (6) @(negedge clk);
    chk("hold_idle_c", 32'(bcd_c), 32'h65535);
    chk("hold_idle_c_ovf", 32'(ovf[2]), 32'd0);

    repeat (3) @(negedge clk);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
